// File: rtl/logic_unit_arbiter_pkg.sv
// Shared encodings for the two-requester bitwise logic arbiter.
package logic_unit_arbiter_pkg;

  // Operation codes carried on reqN_op
  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_ANDN = 2'b11
  } op_e;

  // Arbiter control states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  // Map a raw 2-bit op field onto the enum (every code is legal)
  function automatic op_e to_op(input logic [1:0] raw);
    return op_e'(raw);
  endfunction

endpackage

// File: rtl/logic_unit_arbiter_blu.sv
// Purely combinational bitwise logic unit shared by both requesters.
module bitwise_logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Select the bitwise function; the result never widens or carries
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ANDN: y = a & ~b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of one shared bitwise logic unit.
// One operation is in flight at a time: IDLE accepts, EXEC computes,
// RESP holds the result until the consumer takes it.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
);

  state_e           state_q;
  state_e           state_d;
  logic             prio_q;
  logic             grant0;
  logic             grant1;
  logic             accept;

  op_e              op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             id_p0;
  logic [WIDTH-1:0] y_p0;

  logic [WIDTH-1:0] data_p1;
  logic             id_p1;

  // Grant: a lone valid requester wins; on contention the pointer decides
  always_comb begin
    grant0 = req0_valid && (!req1_valid || !prio_q);
    grant1 = req1_valid && (!req0_valid ||  prio_q);
    accept = (state_q == IDLE) && reset && (grant0 || grant1);
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: EXEC always lasts one cycle, RESP waits for the consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant0 || grant1) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: readiness only in IDLE and never while reset is held
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = reset && grant0;
        req1_ready = reset && grant1;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Stage p0: capture the granted request and hand priority to the other side
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_p0  <= OP_AND;
      a_p0   <= '0;
      b_p0   <= '0;
      id_p0  <= 1'b0;
      prio_q <= 1'b0;
    end else if (accept) begin
      op_p0  <= grant1 ? to_op(req1_op) : to_op(req0_op);
      a_p0   <= grant1 ? req1_a : req0_a;
      b_p0   <= grant1 ? req1_b : req0_b;
      id_p0  <= grant1;
      prio_q <= !grant1;
    end
  end

  bitwise_logic_unit #(
    .WIDTH (WIDTH)
  ) u_blu (
    .op (op_p0),
    .a  (a_p0),
    .b  (b_p0),
    .y  (y_p0)
  );

  // Stage p1: register the result in EXEC; it then holds through RESP
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_p1 <= '0;
      id_p1   <= 1'b0;
    end else if (state_q == EXEC) begin
      data_p1 <= y_p0;
      id_p1   <= id_p0;
    end
  end

  assign rsp_data = data_p1;
  assign rsp_id   = id_p1;

endmodule
